parity_check_stream: RTL and testbench

//  Streaming even/odd parity checker, successor to the combinational 8-bit checker.
//  - Input word: DATA_W data bits plus one parity bit per LANE_W-bit lane.
//  - Checks every lane in one registered stage, behind a valid/ready handshake.
//  - Reports a per-lane error mask, a sticky error flag and an optional saturating error counter.
//  - Sits between the link deserializer and the CRC stage in the error-correction datapath.

---
 rtl/parity_check_stream.sv | 243 ++++++++++++++++++++++++
 tb/tb_parity_check_stream.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_check_stream.sv
// -----------------------------------------------------------------------------
// parity_check_stream
//
// Streaming per-lane parity checker with a one-deep registered output stage
// behind a valid/ready handshake. The block sits between the link deserializer
// and the CRC stage of the error-correction datapath.
//
// Each input word carries DATA_W data bits plus one parity bit per LANE_W-bit
// lane. All lanes are checked in the accept cycle. The per-lane result and the
// unchanged data appear on out_* one cycle later. Error statistics are updated
// at the accept edge, so every word is counted exactly once, whether or not it
// is held by backpressure.
//
// Optional feature macro: PARITY_ERR_CNT_EN
//   defined   : err_cnt port and saturating error counter are present
//   undefined : err_cnt port and counter are omitted; err_clr clears
//               err_sticky only
//
// Parameters
//   DATA_W      data width in bits (multiple of LANE_W)
//   LANE_W      bits covered by each parity bit
//   ODD_PARITY  0: even parity, 1: odd parity
//   ERR_CNT_W   width of err_cnt
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      input word valid
//   in_ready      block can accept the input word (combinational)
//   in_data       data word
//   in_parity     in_parity[i] covers in_data[i*LANE_W +: LANE_W]
//   out_valid     checked word valid
//   out_ready     downstream accepts the checked word
//   out_data      in_data passed through unchanged
//   out_lane_err  bit i set when lane i failed its parity check
//   out_err       OR of out_lane_err
//   err_sticky    set by any accepted erroneous word, cleared by err_clr
//   err_clr       one-cycle pulse clearing err_sticky (and err_cnt)
//   err_cnt       saturating count of accepted erroneous words (macro only)
// -----------------------------------------------------------------------------
module parity_check_stream #(
  parameter int DATA_W     = 32,
  parameter int LANE_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int ERR_CNT_W  = 16,
  localparam int LANES     = DATA_W / ((LANE_W < 1) ? 1 : LANE_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [LANES-1:0]     in_parity,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [LANES-1:0]     out_lane_err,
  output logic                 out_err,
  output logic                 err_sticky,
  input  logic                 err_clr
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // ---------------------------------------------------------------------------
  if (LANE_W < 1) begin : g_bad_lane_w
    $error("parity_check_stream: LANE_W must be at least 1");
  end else if ((DATA_W % LANE_W) != 0) begin : g_bad_data_w
    $error("parity_check_stream: DATA_W must be a multiple of LANE_W");
  end else if (ERR_CNT_W < 1) begin : g_bad_cnt_w
    $error("parity_check_stream: ERR_CNT_W must be at least 1");
  end

  localparam logic ODD_BIT = (ODD_PARITY != 0);

  // Lane parity error: XOR of the lane bits and its parity bit must equal the
  // selected parity sense; any other result flags the lane.
  function automatic logic lane_parity_err(input logic [LANE_W-1:0] lane_data,
                                           input logic              lane_par);
    lane_parity_err = (^lane_data) ^ lane_par ^ ODD_BIT;
  endfunction

  // Output register occupancy
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [LANES-1:0]    out_lane_err_q, out_lane_err_d;
  logic                out_err_q, out_err_d;
  logic                err_sticky_q, err_sticky_d;

  logic [LANES-1:0]    lane_err_s;
  logic                word_err_s;
  logic                accept_s;
  logic                accept_err_s;

  // The stage can take a new word when it is empty or its word leaves now.
  assign out_valid    = (state_q == ST_FULL);
  assign in_ready     = (state_q != ST_FULL) || out_ready;
  assign accept_s     = in_valid && in_ready;
  assign word_err_s   = |lane_err_s;
  assign accept_err_s = accept_s && word_err_s;

  assign out_data     = out_data_q;
  assign out_lane_err = out_lane_err_q;
  assign out_err      = out_err_q;
  assign err_sticky   = err_sticky_q;

  // Per-lane parity evaluation of the word presented on the input.
  always_comb begin
    lane_err_s = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_err_s[i] = lane_parity_err(in_data[i*LANE_W +: LANE_W], in_parity[i]);
    end
  end

  // Output stage next state: load on accept, drain on delivery, else hold.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept_s) begin
          state_d = ST_FULL;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Output payload next values: only an accepted word replaces the payload,
  // so a held word stays stable under backpressure.
  always_comb begin
    out_data_d     = out_data_q;
    out_lane_err_d = out_lane_err_q;
    out_err_d      = out_err_q;
    if (accept_s) begin
      out_data_d     = in_data;
      out_lane_err_d = lane_err_s;
      out_err_d      = word_err_s;
    end else begin
      out_data_d     = out_data_q;
      out_lane_err_d = out_lane_err_q;
      out_err_d      = out_err_q;
    end
  end

  // Sticky flag: the clear takes effect first so an error accepted in the
  // same cycle as err_clr is still recorded.
  always_comb begin
    err_sticky_d = err_sticky_q;
    if (err_clr) begin
      err_sticky_d = accept_err_s;
    end else begin
      err_sticky_d = err_sticky_q || accept_err_s;
    end
  end

  // Output stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q     <= '0;
      out_lane_err_q <= '0;
      out_err_q      <= 1'b0;
    end else begin
      out_data_q     <= out_data_d;
      out_lane_err_q <= out_lane_err_d;
      out_err_q      <= out_err_d;
    end
  end

  // Sticky error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_CNT_W-1:0] cnt_base_s;

  assign err_cnt = err_cnt_q;

  // Saturating word-error counter: clear first, then count the accepted word.
  always_comb begin
    cnt_base_s = err_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (err_clr) begin
      cnt_base_s = '0;
    end else begin
      cnt_base_s = err_cnt_q;
    end
    if (accept_err_s && (cnt_base_s != CNT_MAX)) begin
      err_cnt_d = cnt_base_s + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_d = cnt_base_s;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_parity_check_stream.sv
// -----------------------------------------------------------------------------
// tb_parity_check_stream
//
// Self-checking bench for parity_check_stream. An even-parity instance with a
// 4-bit error counter carries the main traffic; an odd-parity instance covers
// the odd-parity sense. Expected outputs come from a queue-based reference
// model that recomputes lane errors with population counts.
// -----------------------------------------------------------------------------
module tb_parity_check_stream;

  localparam int DW = 32;
  localparam int LW = 8;
  localparam int NL = 4;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [NL-1:0] in_parity, out_lane_err;
  logic          out_err, err_sticky, err_clr;

  logic          o_in_valid, o_in_ready, o_out_valid, o_out_ready;
  logic [DW-1:0] o_in_data, o_out_data;
  logic [NL-1:0] o_in_parity, o_out_lane_err;
  logic          o_out_err, o_err_sticky, o_err_clr;

`ifdef PARITY_ERR_CNT_EN
  logic [CW-1:0] err_cnt, o_err_cnt;
`endif

  parity_check_stream #(.DATA_W(DW), .LANE_W(LW), .ODD_PARITY(0), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_parity(in_parity),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane_err(out_lane_err), .out_err(out_err),
    .err_sticky(err_sticky), .err_clr(err_clr)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  parity_check_stream #(.DATA_W(DW), .LANE_W(LW), .ODD_PARITY(1), .ERR_CNT_W(CW)) dut_odd (
    .clk(clk), .rst_n(rst_n),
    .in_valid(o_in_valid), .in_ready(o_in_ready), .in_data(o_in_data), .in_parity(o_in_parity),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .out_data(o_out_data),
    .out_lane_err(o_out_lane_err), .out_err(o_out_err),
    .err_sticky(o_err_sticky), .err_clr(o_err_clr)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt(o_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NL-1:0] lerr;
  } word_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  word_t         exp_q[$];          // words the model says sit in the output stage
  logic [35:0]   src_q[$];          // pending source words {parity, data}
  bit            model_sticky;
  int            model_cnt;
  int            dut_deliv = 0;
  int            model_deliv = 0;

  // Lane error from the parity rule: count ones in lane plus parity bit.
  function automatic logic [NL-1:0] model_lane_err(input logic [DW-1:0] d,
                                                    input logic [NL-1:0] p,
                                                    input bit odd);
    logic [NL-1:0] r;
    int ones;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      ones = $countones(d[i*LW +: LW]) + int'(p[i]);
      r[i] = ((ones % 2) != (odd ? 1 : 0));
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_data", 64'(out_data), 64'(exp_q[0].data));
      check("out_lane_err", 64'(out_lane_err), 64'(exp_q[0].lerr));
      check("out_err", 64'(out_err), 64'(|exp_q[0].lerr));
    end
    check("err_sticky", 64'(err_sticky), 64'(model_sticky));
`ifdef PARITY_ERR_CNT_EN
    check("err_cnt", 64'(err_cnt), 64'(model_cnt));
`endif
  endtask

  // One clock cycle: offer the head of src_q, advance the model, check outputs.
  task automatic cycle(input bit ordy, input bit clr);
    bit            offer, exp_rdy, acc;
    logic [35:0]   w;
    logic [NL-1:0] le;
    offer = (src_q.size() != 0);
    if (offer) w = src_q[0];
    else       w = {4'($urandom), 32'($urandom)};
    in_valid  = offer;
    in_data   = w[31:0];
    in_parity = w[35:32];
    out_ready = ordy;
    err_clr   = clr;
    #1;
    exp_rdy = (exp_q.size() == 0) || ordy;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (out_valid && out_ready) dut_deliv++;
    acc = offer && exp_rdy;
    if ((exp_q.size() != 0) && ordy) begin
      void'(exp_q.pop_front());
      model_deliv++;
    end
    le = model_lane_err(w[31:0], w[35:32], 1'b0);
    if (clr) begin
      model_sticky = 1'b0;
      model_cnt    = 0;
    end
    if (acc) begin
      exp_q.push_back({w[31:0], le});
      void'(src_q.pop_front());
      if (le != '0) begin
        model_sticky = 1'b1;
        if (model_cnt < CNT_MAX) model_cnt++;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Random word whose parity is wrong in at least one lane.
  function automatic logic [35:0] bad_word();
    logic [31:0] d;
    logic [3:0]  good;
    d    = $urandom;
    good = model_lane_err(d, 4'b0000, 1'b0);
    return {good ^ 4'($urandom_range(1, 15)), d};
  endfunction

  initial begin
    int          d0;
    logic [35:0] first;

    rst_n = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_parity = 4'hF;
    out_ready = 1'b0; err_clr = 1'b0;
    o_in_valid = 1'b0; o_in_data = 32'h0; o_in_parity = 4'h0;
    o_out_ready = 1'b1; o_err_clr = 1'b0;
    model_sticky = 1'b0; model_cnt = 0;

    // Reset with in_valid held high
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_lane_err", 64'(out_lane_err), 64'd0);
    check("rst_err_sticky", 64'(err_sticky), 64'd0);
`ifdef PARITY_ERR_CNT_EN
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Even parity, clean and single-lane error words
    src_q.push_back({4'b1000, 32'h0103_00FF});
    cycle(1'b1, 1'b0);
    check("t2_clean_lane_err", 64'(out_lane_err), 64'h0);
    check("t2_clean_data", 64'(out_data), 64'h0103_00FF);
    src_q.push_back({4'b1001, 32'h0103_00FF});
    cycle(1'b1, 1'b0);
    check("t2_bad_lane_err", 64'(out_lane_err), 64'h1);
    check("t2_bad_sticky", 64'(err_sticky), 64'd1);
`ifdef PARITY_ERR_CNT_EN
    check("t2_bad_cnt", 64'(err_cnt), 64'd1);
`endif
    cycle(1'b1, 1'b1);
    check("t2_clr_sticky", 64'(err_sticky), 64'd0);

    // Backpressure: three words offered while downstream stalls
    for (int i = 0; i < 3; i++) src_q.push_back({4'($urandom), 32'($urandom)});
    first = src_q[0];
    repeat (4) cycle(1'b0, 1'b0);
    check("t3_held_data", 64'(out_data), 64'(first[31:0]));
    check("t3_in_ready_low", 64'(in_ready), 64'd0);
    d0 = dut_deliv;
    repeat (4) cycle(1'b1, 1'b0);
    check("t3_delivered", 64'(dut_deliv - d0), 64'd3);

    // Throughput: 100 words back to back
    d0 = dut_deliv;
    for (int i = 0; i < 100; i++) src_q.push_back({4'($urandom), 32'($urandom)});
    repeat (101) cycle(1'b1, 1'b0);
    check("t4_delivered", 64'(dut_deliv - d0), 64'd100);

    // Random traffic with random backpressure and occasional clears
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 1) != 0) src_q.push_back(bad_word());
        else src_q.push_back({4'($urandom), 32'($urandom)});
      end
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
    while (src_q.size() != 0 && n_checks < 20000) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("rand_deliveries", 64'(dut_deliv), 64'(model_deliv));

    // Saturation and clear interaction
    for (int i = 0; i < 20; i++) src_q.push_back(bad_word());
    repeat (21) cycle(1'b1, 1'b0);
    check("t5_sticky", 64'(err_sticky), 64'd1);
`ifdef PARITY_ERR_CNT_EN
    check("t5_saturated", 64'(err_cnt), 64'(CNT_MAX));
`endif
    src_q.push_back(bad_word());
    cycle(1'b1, 1'b1);
    check("t5_clr_err_sticky", 64'(err_sticky), 64'd1);
`ifdef PARITY_ERR_CNT_EN
    check("t5_clr_err_cnt", 64'(err_cnt), 64'd1);
`endif
    cycle(1'b1, 1'b1);
    check("t5_clr_alone_sticky", 64'(err_sticky), 64'd0);
`ifdef PARITY_ERR_CNT_EN
    check("t5_clr_alone_cnt", 64'(err_cnt), 64'd0);
`endif

    // Reset while a word is held under backpressure
    src_q.push_back(bad_word());
    cycle(1'b0, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    model_sticky = 1'b0;
    model_cnt = 0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_sticky", 64'(err_sticky), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 1'b0);

    // Odd parity instance
    o_in_valid = 1'b1; o_in_data = 32'h0; o_in_parity = 4'b1111;
    @(posedge clk);
    #1;
    check("t6_odd_ok_err", 64'(o_out_err), 64'(|model_lane_err(32'h0, 4'b1111, 1'b1)));
    check("t6_odd_ok_lane", 64'(o_out_lane_err), 64'h0);
    o_in_parity = 4'b0000;
    @(posedge clk);
    #1;
    check("t6_odd_bad_lane", 64'(o_out_lane_err), 64'(model_lane_err(32'h0, 4'b0000, 1'b1)));
    check("t6_odd_bad_const", 64'(o_out_lane_err), 64'hF);
    check("t6_odd_sticky", 64'(o_err_sticky), 64'd1);
    o_in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
